// File: rtl/fanin_arb.sv
// fanin_arb: arbitrates NUM_REQ FanIn buffers onto one shared output link.
// One requester at a time owns the link from grant until the downstream
// signals end-of-transfer (I_BTk.t) or the owner has gone idle for MAX_IDLE
// cycles. A single RELEASE cycle then advances the round-robin pointer.
// Requesters with a full buffer are preferred over ordinary requesters.

package fanin_arb_pkg;
    localparam int DATA_W = 16;

    // Forward token: .v is the valid/request bit, .d the payload.
    typedef struct packed {
        logic              v;
        logic [DATA_W-1:0] d;
    } FTk_t;

    // Back-prop token: .n = not-ready (stall), .t = end-of-transfer.
    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;
endpackage

// Per-buffer output shaping; one instance per requester.
module fanin_lane
    import fanin_arb_pkg::*;
(
    input  logic st_grant,
    input  logic st_rel,
    input  logic sel,
    input  logic req_v,
    input  BTk_t bk_in,
    output BTk_t bk_out,
    output logic en,
    output logic stop,
    output logic gnt
);
    // Granted lane sees the downstream token; the others are stalled and held.
    always_comb begin
        bk_out = '0;
        en     = 1'b1;
        stop   = req_v;
        gnt    = 1'b0;
        if (st_grant) begin
            if (sel) begin
                bk_out = bk_in;
                stop   = 1'b0;
                gnt    = 1'b1;
            end else begin
                bk_out.n = 1'b1;
                bk_out.t = 1'b0;
                stop     = 1'b1;
            end
        end else if (st_rel) begin
            stop = 1'b1;
        end
    end
endmodule

module fanin_arb
    import fanin_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_IDLE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  FTk_t [NUM_REQ-1:0]    I_FTk,
    output BTk_t [NUM_REQ-1:0]    O_BTk,
    input  logic [NUM_REQ-1:0]    I_Full,
    output logic [NUM_REQ-1:0]    O_En,
    output logic [NUM_REQ-1:0]    O_Stop,
    output FTk_t                  O_FTk,
    input  BTk_t                  I_BTk,
    output logic [NUM_REQ-1:0]    O_Gnt
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]         state;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   r_ptr;
    logic [7:0]         r_idle;

    logic [NUM_REQ-1:0] req_v;
    logic               any_v;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   g_next;
    logic               owner_v;
    logic               idle_hit;
    logic               rel;

    // Gather request bits so the search below works on a plain vector.
    always_comb begin
        req_v = '0;
        for (int i = 0; i < NUM_REQ; i++) req_v[i] = I_FTk[i].v;
    end

    assign any_v = |req_v;

    // Rotating search from r_ptr; a full+valid requester beats a plain one.
    always_comb begin
        logic             found;
        logic             found_full;
        logic [IDX_W-1:0] win_v;
        logic [IDX_W-1:0] win_f;
        int               idx;
        found      = 1'b0;
        found_full = 1'b0;
        win_v      = '0;
        win_f      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_v[idx]) begin
                found = 1'b1;
                win_v = IDX_W'(idx);
            end
            if (!found_full && req_v[idx] && I_Full[idx]) begin
                found_full = 1'b1;
                win_f      = IDX_W'(idx);
            end
        end
        win = found_full ? win_f : win_v;
    end

    assign g_next  = (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    assign owner_v = req_v[g];

    // Idle release fires on the cycle whose increment would reach MAX_IDLE,
    // so RELEASE lands MAX_IDLE+1 cycles after the owner's last valid.
    assign idle_hit = !owner_v && !I_BTk.n &&
                      (({1'b0, r_idle} + 9'd1) >= 9'(MAX_IDLE));
    // Either condition (or both at once) gives a single release.
    assign rel = I_BTk.t || idle_hit;

    // State, owner, pointer and idle counter; reset aborts any transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            g      <= '0;
            r_ptr  <= '0;
            r_idle <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_v) begin
                        state  <= GRANT;
                        g      <= win;
                        r_idle <= '0;
                    end
                end
                GRANT: begin
                    if (rel) state <= RELEASE;
                    if (owner_v)
                        r_idle <= '0;
                    else if (!I_BTk.n && r_idle != 8'hFF)
                        r_idle <= r_idle + 8'd1;
                end
                RELEASE: begin
                    r_ptr <= g_next;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared link carries the owner's token only while granted.
    always_comb begin
        O_FTk = '0;
        if (state == GRANT) O_FTk = I_FTk[g];
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fanin_lane u_lane (
            .st_grant (state == GRANT),
            .st_rel   (state == RELEASE),
            .sel      (g == IDX_W'(i)),
            .req_v    (req_v[i]),
            .bk_in    (I_BTk),
            .bk_out   (O_BTk[i]),
            .en       (O_En[i]),
            .stop     (O_Stop[i]),
            .gnt      (O_Gnt[i])
        );
    end
endmodule
